sc_frontend_sequencer: RTL
==========================

// Module: sc_frontend_sequencer
// PURPOSE
// - Multi-channel phase sequencer for the switched-capacitor ECG front-end.
// - Per channel, drives the cap switch controls s2..s6 through RESET -> SAMPLE -> HOLD.
// - Pulses an ADC trigger in each HOLD phase.
// - Walks ch_sel through NCH channels per start request, then returns to IDLE with a done pulse.
// PARAMETERS
// - RST_CYC  2  cycles in RESET phase (>=1)
// - SMP_CYC  8  cycles in SAMPLE phase (>=1)
// - HLD_CYC  4  cycles in HOLD phase (>=1)
// - DT_CYC   1  dead-time cycles per transition (>=1, used only with SC_DEADTIME_EN)
// - NCH      3  channels per sweep (>=1)
// - CHW      2  ch_sel width, 2**CHW >= NCH
// PORTS
// - clk        in   1    system clock; all outputs registered on posedge
// - rst_n      in   1    asynchronous active-low reset
// - start      in   1    sweep request, sampled in IDLE only
// - abort      in   1    synchronous abort, valid in any state
// - busy       out  1    high in every non-IDLE state
// - done       out  1    1-cycle pulse when a sweep completes normally
// - adc_trig   out  1    1-cycle pulse on the first HOLD cycle of each channel
// - ch_sel     out  CHW  channel being sequenced
// - state      out  2    phase code: 00 RESET, 01 SAMPLE, 10 HOLD, 11 IDLE
// - s2,s3,s4,s5,s6  out  1 each  switch controls, 1 = closed
// BEHAVIOUR
// Reset and output patterns
// - Reset (async): state=11, s3=s6=1, s2=s4=s5=0, busy=0, done=0, adc_trig=0, ch_sel=0, counters=0.
// - IDLE:   s3=s6=1, others 0 (caps shorted).
// - RESET:  s3=s6=1, others 0.
// - SAMPLE: s2=s4=s5=1, s3=s6=0.
// - HOLD:   s4=s5=1, s2=s3=s6=0.
// FSM transitions
// - IDLE: start=1 and abort=0 -> RESET. The first RESET cycle is registered on the same edge (1-cycle latency).
// - RESET: lasts RST_CYC cycles, then SAMPLE.
// - SAMPLE: lasts SMP_CYC cycles, then HOLD.
// - HOLD: lasts HLD_CYC cycles; adc_trig=1 only on its first cycle.
// - HOLD end, ch_sel<NCH-1: ch_sel+1, then RESET.
// - HOLD end, ch_sel==NCH-1: ch_sel=0, IDLE, done=1 in the first IDLE cycle.
// Control rules
// - Phase timing: one down-counter, width clog2(max cycle param)+1, reloaded on each phase entry; no wrap.
// - start while busy: ignored, never queued.
// - start and abort in the same IDLE cycle: abort wins, stay IDLE.
// - abort=1 in any busy state: next edge -> IDLE pattern, ch_sel=0, done=0, adc_trig=0.
// - abort in the first HOLD cycle: the adc_trig of that cycle has already been issued; it is not cancelled.
// - Per-channel length without the macro: RST_CYC+SMP_CYC+HLD_CYC cycles.
// - NCH=1: a single channel per sweep; ch_sel stays 0.
// CONFIGURATION
// - SC_DEADTIME_EN defined:
//   - DT_CYC cycles with s2..s6 all 0 on RESET->SAMPLE, SAMPLE->HOLD, HOLD->RESET and HOLD->IDLE.
//   - No dead-time on IDLE->RESET, where the switch pattern is unchanged.
//   - During dead-time, state keeps the previous phase code and busy=1.
//   - On HOLD->IDLE, done pulses after the dead-time.
//   - Per-channel length: RST+SMP+HLD+3*DT_CYC.
//   - abort during dead-time -> IDLE next edge.
// - SC_DEADTIME_EN undefined: direct phase-to-phase transitions; DT_CYC is unused.
// TESTING (defaults)
// - rst_n low mid-SAMPLE of channel 1 -> outputs match the reset row at once, asynchronously, before any clk edge.
// - start pulse at edge 0, no macro -> state 00 for edges 1-2, 01 for 3-10, 10 for 11-14, adc_trig at edge 11; ch_sel=1 at edge 15; done at edge 43 (3x14 cycles), busy low at the same edge.
// - Same stimulus with SC_DEADTIME_EN -> all switches 0 at edges 3, 12 and 17; done at edge 52 (3x17 cycles).
// - Second start pulse during channel 2 -> no effect; done still once at edge 43.
// - abort at edge 20 (channel 1 SAMPLE) -> state=11, ch_sel=0, s3=s6=1 at edge 21; no done.
// - start and abort together in IDLE -> stays IDLE, busy=0; then start alone -> sequence begins.

Source files
------------

// File: rtl/sc_frontend_sequencer.sv
// Multi-channel RESET/SAMPLE/HOLD switch sequencer for the switched-capacitor ECG front-end.
// Optional macro SC_DEADTIME_EN inserts DT_CYC all-open cycles between switch patterns.
module sc_frontend_sequencer #(
    parameter int RST_CYC = 2,
    parameter int SMP_CYC = 8,
    parameter int HLD_CYC = 4,
    parameter int DT_CYC  = 1,
    parameter int NCH     = 3,
    parameter int CHW     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           adc_trig,
    output logic [CHW-1:0] ch_sel,
    output logic [1:0]     state,
    output logic           s2,
    output logic           s3,
    output logic           s4,
    output logic           s5,
    output logic           s6
);

    localparam int MAX_RS = (RST_CYC > SMP_CYC) ? RST_CYC : SMP_CYC;
    localparam int MAX_HD = (HLD_CYC > DT_CYC) ? HLD_CYC : DT_CYC;
    localparam int MAXC   = (MAX_RS > MAX_HD) ? MAX_RS : MAX_HD;
    localparam int CW     = $clog2(MAXC) + 1;

    localparam logic [1:0] ST_RESET  = 2'b00;
    localparam logic [1:0] ST_SAMPLE = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;
    localparam logic [1:0] ST_IDLE   = 2'b11;

    localparam logic [CW-1:0]  LD_RST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0]  LD_SMP  = CW'(SMP_CYC - 1);
    localparam logic [CW-1:0]  LD_HLD  = CW'(HLD_CYC - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

    // switch vectors ordered {s2,s3,s4,s5,s6}
    localparam logic [4:0] SW_SHORT  = 5'b01001;
    localparam logic [4:0] SW_SAMPLE = 5'b10110;
    localparam logic [4:0] SW_HOLD   = 5'b00110;

    logic [1:0]     r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [CHW-1:0] r_ch, w_ch;
    logic           r_busy, r_done, r_trig;
    logic           w_done, w_trig;
    logic [4:0]     r_sw, w_sw;
`ifdef SC_DEADTIME_EN
    localparam logic [CW-1:0] LD_DT = CW'(DT_CYC - 1);
    logic r_dt, w_dt;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ch    = r_ch;
        w_done  = 1'b0;
        w_trig  = 1'b0;
`ifdef SC_DEADTIME_EN
        w_dt    = r_dt;
`endif
        if (r_state == ST_IDLE) begin
            if (start && !abort) begin
                w_state = ST_RESET;
                w_cnt   = LD_RST;
            end
        end else if (abort) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_ch    = '0;
`ifdef SC_DEADTIME_EN
            w_dt    = 1'b0;
`endif
        end else if (r_cnt != '0) begin
            w_cnt = r_cnt - CW'(1);
`ifdef SC_DEADTIME_EN
        end else if (!r_dt) begin
            // phase expired: hold the phase code with all switches open first
            w_dt  = 1'b1;
            w_cnt = LD_DT;
`endif
        end else begin
`ifdef SC_DEADTIME_EN
            w_dt = 1'b0;
`endif
            case (r_state)
                ST_RESET: begin
                    w_state = ST_SAMPLE;
                    w_cnt   = LD_SMP;
                end
                ST_SAMPLE: begin
                    w_state = ST_HOLD;
                    w_cnt   = LD_HLD;
                    w_trig  = 1'b1;
                end
                default: begin
                    if (r_ch == CH_LAST) begin
                        w_state = ST_IDLE;
                        w_cnt   = '0;
                        w_ch    = '0;
                        w_done  = 1'b1;
                    end else begin
                        w_state = ST_RESET;
                        w_cnt   = LD_RST;
                        w_ch    = r_ch + CHW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (w_state)
            ST_SAMPLE: w_sw = SW_SAMPLE;
            ST_HOLD:   w_sw = SW_HOLD;
            default:   w_sw = SW_SHORT;
        endcase
`ifdef SC_DEADTIME_EN
        if (w_dt) w_sw = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_trig  <= 1'b0;
            r_sw    <= SW_SHORT;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ch    <= w_ch;
            r_busy  <= (w_state != ST_IDLE);
            r_done  <= w_done;
            r_trig  <= w_trig;
            r_sw    <= w_sw;
        end
    end

`ifdef SC_DEADTIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dt <= 1'b0;
        else        r_dt <= w_dt;
    end
`endif

    assign state    = r_state;
    assign busy     = r_busy;
    assign done     = r_done;
    assign adc_trig = r_trig;
    assign ch_sel   = r_ch;
    assign s2       = r_sw[4];
    assign s3       = r_sw[3];
    assign s4       = r_sw[2];
    assign s5       = r_sw[1];
    assign s6       = r_sw[0];

endmodule
